// File: rtl/flit_rx_fifo.sv
// Router input-port flit FIFO with a one-flit-at-a-time RTS/CTS handshake
// toward the upstream arbiter and a five-way pop from the output arbiters.
module flit_rx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DRTS,
    input  logic [DATA_WIDTH-1:0] RX,
    output logic                  CTS,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty_out,
    output logic                  full_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic                  cts_q;
    logic                  cts_d;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    logic                  empty_s;
    logic                  full_s;
    logic                  pop_req_s;
    logic                  do_pop_s;
    logic                  do_write_s;

    // Occupancy decode, pop qualification and write qualification.
    always_comb begin
        empty_s    = (count_q == {CNT_W{1'b0}});
        full_s     = (count_q == CNT_W'(DEPTH));
        pop_req_s  = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
        do_pop_s   = pop_req_s & ~empty_s;
        // A write at full is a protocol error and is dropped rather than overwriting the head.
        do_write_s = cts_q & DRTS & ~full_s;
    end

    // Next-state computation for handshake, pointers and occupancy.
    always_comb begin
        cts_d    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Full is sampled before any same-cycle pop, so a pop never grants CTS early.
        if (DRTS && !cts_q && !full_s) begin
            cts_d = 1'b1;
        end else begin
            cts_d = 1'b0;
        end

        if (do_write_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({do_write_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_q    <= 1'b0;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            cts_q    <= cts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flit storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_write_s && !rst) begin
            mem_q[wr_ptr_q] <= RX;
        end
    end

    assign CTS       = cts_q;
    assign Data_out  = mem_q[rd_ptr_q];
    assign empty_out = empty_s;
    assign full_out  = full_s;

endmodule
